// File: rtl/countdown_pkg.sv
// Shared types and constants for the M:SS.d countdown timer.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_e;

    localparam int DECI_MAX = 9;
    localparam int SEC0_MAX = 9;
    localparam int SEC1_MAX = 5;
    localparam int MIN_MAX  = 9;

    localparam int MIN_W  = 4;
    localparam int SEC1_W = 3;
    localparam int SEC0_W = 4;
    localparam int DECI_W = 4;

    function automatic logic [3:0] clamp4(input logic [3:0] v, input logic [3:0] mx);
        return (v > mx) ? mx : v;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One down-counting digit; wraps 0 -> MAX and raises a borrow for the next digit.
module bcd_down_digit #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_en_i,
    output logic [W-1:0] value_o,
    output logic         borrow_o
);

    logic [W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load_i)
            value_d = load_val_i;
        else if (dec_en_i)
            value_d = (value_q == W'(0)) ? W'(MAX) : value_q - W'(1);
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n)
            value_q <= '0;
        else
            value_q <= value_d;
    end

    assign value_o  = value_q;
    assign borrow_o = dec_en_i && (value_q == W'(0));

endmodule

// File: rtl/countdown_timer.sv
// Decisecond countdown timer: FSM, tick divider, preset clamping and the digit chain.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       load,
    input  logic       start,
    input  logic       pause,
    input  logic [3:0] p_min,
    input  logic [2:0] p_sec1,
    input  logic [3:0] p_sec0,
    input  logic [3:0] p_deci,
    output logic [3:0] min,
    output logic [2:0] sec1,
    output logic [3:0] sec0,
    output logic [3:0] deci,
    output logic       running,
    output logic       expired,
    output logic       done
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             done_q, done_d;
    logic             ld_en, dec, tick, is_zero, is_one;

    logic [MIN_W-1:0]  min_v;
    logic [SEC1_W-1:0] sec1_v;
    logic [SEC0_W-1:0] sec0_v;
    logic [DECI_W-1:0] deci_v;
    logic              deci_bo, sec0_bo, sec1_bo, min_bo_unused;

    logic [MIN_W-1:0]  ld_min;
    logic [SEC1_W-1:0] ld_sec1;
    logic [SEC0_W-1:0] ld_sec0;
    logic [DECI_W-1:0] ld_deci;

    assign ld_min  = clamp4(p_min,  4'(MIN_MAX));
    assign ld_sec0 = clamp4(p_sec0, 4'(SEC0_MAX));
    assign ld_deci = clamp4(p_deci, 4'(DECI_MAX));
    assign ld_sec1 = (p_sec1 > 3'(SEC1_MAX)) ? 3'(SEC1_MAX) : p_sec1;

    assign is_zero = (min_v == '0) && (sec1_v == '0) && (sec0_v == '0) && (deci_v == '0);
    assign is_one  = (min_v == '0) && (sec1_v == '0) && (sec0_v == '0) && (deci_v == 4'd1);
    assign tick    = (state_q == RUN) && (div_q == DIV_W'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        div_d   = '0;
        ld_en   = 1'b0;
        dec     = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE, PAUSE: begin
                if (load) begin
                    ld_en   = 1'b1;
                    state_d = IDLE;
                end else if (start && !is_zero) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // pause wins over a coincident tick; the partial period is dropped
                if (pause) begin
                    state_d = PAUSE;
                end else if (tick) begin
                    dec = 1'b1;
                    if (is_one) begin
                        state_d = EXPIRED;
                        done_d  = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            EXPIRED: begin
                if (load) begin
                    ld_en   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            done_q  <= done_d;
        end
    end

    bcd_down_digit #(.MAX(DECI_MAX), .W(DECI_W)) u_deci (
        .clk(clk), .clr_n(clr_n), .load_i(ld_en), .load_val_i(ld_deci),
        .dec_en_i(dec), .value_o(deci_v), .borrow_o(deci_bo)
    );
    bcd_down_digit #(.MAX(SEC0_MAX), .W(SEC0_W)) u_sec0 (
        .clk(clk), .clr_n(clr_n), .load_i(ld_en), .load_val_i(ld_sec0),
        .dec_en_i(deci_bo), .value_o(sec0_v), .borrow_o(sec0_bo)
    );
    bcd_down_digit #(.MAX(SEC1_MAX), .W(SEC1_W)) u_sec1 (
        .clk(clk), .clr_n(clr_n), .load_i(ld_en), .load_val_i(ld_sec1),
        .dec_en_i(sec0_bo), .value_o(sec1_v), .borrow_o(sec1_bo)
    );
    // minutes never borrow: expiry stops the chain at 0:00.0
    bcd_down_digit #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
        .clk(clk), .clr_n(clr_n), .load_i(ld_en), .load_val_i(ld_min),
        .dec_en_i(sec1_bo), .value_o(min_v), .borrow_o(min_bo_unused)
    );

    assign min     = min_v;
    assign sec1    = sec1_v;
    assign sec0    = sec0_v;
    assign deci    = deci_v;
    assign running = (state_q == RUN);
    assign expired = (state_q == EXPIRED);
    assign done    = done_q;

endmodule
